// File: rtl/pixel_stream_vga_sink_if.sv
// Pixel stream handshake bundle: 24-bit RGB beat with frame/line markers.
interface pixel_stream_vga_sink_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       first;
    logic       last_x;
    logic       last_y;
    logic       valid;
    logic       ready;

    modport master (output r, g, b, first, last_x, last_y, valid, input ready);
    modport slave  (input r, g, b, first, last_x, last_y, valid, output ready);
endinterface

// File: rtl/pixel_stream_vga_sink.sv
// Stream-to-VGA sink: buffers framed pixel beats, validates framing against the
// local raster and replays pixels with registered sync/enable timing.
module pixel_stream_vga_sink #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    pixel_stream_vga_sink_if.slave        stream,
    output logic [7:0]                    vga_r_o,
    output logic [7:0]                    vga_g_o,
    output logic [7:0]                    vga_b_o,
    output logic                          hsync_o,
    output logic                          vsync_o,
    output logic                          de_o,
    output logic                          frame_error_o,
    output logic                          underflow_o
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = 27;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ARMED,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hCnt_q, hCnt_d;
    logic [VW-1:0]   vCnt_q, vCnt_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [AW:0]     count_q;
    logic [23:0]     vgaRgb_q;
    logic            de_q, hsync_q, vsync_q, frameError_q, underflow_q;

    int              hPos, vPos;
    logic            lastH, lastV, active, hSyncWin, vSyncWin;
    logic            full, empty, mismatch;
    logic [EW-1:0]   head, entry;
    logic            readyInt, push, pop, flush, frameErr, underErr;

    assign hPos     = int'(hCnt_q);
    assign vPos     = int'(vCnt_q);
    assign lastH    = (hPos == H_TOTAL - 1);
    assign lastV    = (vPos == V_TOTAL - 1);
    assign active   = (hPos < H_ACTIVE) && (vPos < V_ACTIVE);
    assign hSyncWin = (hPos >= HS_START) && (hPos < HS_END);
    assign vSyncWin = (vPos >= VS_START) && (vPos < VS_END);
    assign hCnt_d   = lastH ? '0 : hCnt_q + HW'(1);
    assign vCnt_d   = !lastH ? vCnt_q : (lastV ? '0 : vCnt_q + VW'(1));

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rdPtr_q];
    assign entry = {stream.r, stream.g, stream.b, stream.first, stream.last_x, stream.last_y};

    // Head entry layout: [26:3] rgb, [2] first, [1] last_x, [0] last_y.
    assign mismatch = (head[2] != ((hPos == 0) && (vPos == 0))) ||
                      (head[1] != (hPos == H_ACTIVE - 1)) ||
                      (head[0] != (vPos == V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC_WAIT;
            hCnt_q  <= '0;
            vCnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hCnt_q  <= hCnt_d;
            vCnt_q  <= vCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC_WAIT: if (stream.valid && stream.first) state_d = ARMED;
            ARMED:     if (lastH && lastV) state_d = RUN;
            RUN:       if (active && (empty || mismatch)) state_d = SYNC_WAIT;
            default:   state_d = SYNC_WAIT;
        endcase
    end

    // A fault flushes the FIFO; a beat accepted on that same cycle is dropped.
    always_comb begin
        readyInt = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        frameErr = 1'b0;
        underErr = 1'b0;
        if (!reset) begin
            case (state_q)
                SYNC_WAIT: begin
                    readyInt = 1'b1;
                    push     = stream.valid && stream.first;
                end
                ARMED: begin
                    readyInt = !full;
                    push     = stream.valid && !full;
                end
                RUN: begin
                    readyInt = !full;
                    push     = stream.valid && !full;
                    if (active) begin
                        if (empty) begin
                            underErr = 1'b1;
                            flush    = 1'b1;
                        end else begin
                            pop = 1'b1;
                            if (mismatch) begin
                                frameErr = 1'b1;
                                flush    = 1'b1;
                            end
                        end
                    end
                end
                default: readyInt = 1'b0;
            endcase
        end
    end

    assign stream.ready = readyInt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!push && pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wrPtr_q] <= entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vgaRgb_q     <= '0;
            de_q         <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frameError_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            vgaRgb_q     <= pop ? head[26:3] : 24'd0;
            de_q         <= active;
            hsync_q      <= !hSyncWin;
            vsync_q      <= !vSyncWin;
            frameError_q <= frameErr;
            underflow_q  <= underErr;
        end
    end

    assign vga_r_o       = vgaRgb_q[23:16];
    assign vga_g_o       = vgaRgb_q[15:8];
    assign vga_b_o       = vgaRgb_q[7:0];
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_error_o = frameError_q;
    assign underflow_o   = underflow_q;
endmodule
